damage_tracker: RTL
===================

DAMAGE_TRACKER -- requirements
Module: damage_tracker

Interface
REQ-001 SHALL have parameter HIT_DAMAGE, default 8'd16, damage added to the opponent per landed hit.
REQ-002 SHALL have parameter DEATH_LEVEL, default 8'd192, damage value at which a player is dead; saturation ceiling.
REQ-003 SHALL have parameter COOLDOWN_CYCLES, default 24'd6_250_000 (0.25 s at 25 MHz), attacker lockout length in clocks.
REQ-004 SHALL have parameter ATK_L_KEY, default 8'h09, left-player attack keycode.
REQ-005 SHALL have parameter ATK_R_KEY, default 8'h10, right-player attack keycode.
REQ-006 clk_25MHz  input  1  system clock; all state on its rising edge.
REQ-007 Reset  input  1  asynchronous, active-high reset.
REQ-008 keycode, keycode1, keycode2, keycode3  input  8 each  current USB keyboard keycodes; 8'h00 = none.
REQ-009 fighting  input  1  high while the match is in progress.
REQ-010 in_reach  input  1  high when the fighters are close enough for a hit to land.
REQ-011 healthL  output  8  accumulated damage on the left player, 0..DEATH_LEVEL.
REQ-012 healthR  output  8  accumulated damage on the right player, 0..DEATH_LEVEL.
REQ-013 hitL, hitR  output  1 each  one-cycle pulse when damage is applied to the left/right player.

Function
REQ-014 SHALL define pressL/pressR = any of the four keycodes equals ATK_L_KEY/ATK_R_KEY.
REQ-015 SHALL register pressL/pressR each cycle; an attack event is press high now and registered press low (rising edge only; held keys produce one event).
REQ-016 SHALL run one two-state FSM per attacker: READY, COOLDOWN.
REQ-017 READY + attack event + fighting=1 + no player dead -> COOLDOWN, counter loaded with COOLDOWN_CYCLES-1.
REQ-018 Attack event with in_reach=0 SHALL still enter COOLDOWN (whiff) but apply no damage and no hit pulse.
REQ-019 COOLDOWN: counter decrements each cycle; at counter=0 -> READY next cycle; attack events in COOLDOWN SHALL be ignored.
REQ-020 Landed hit (event accepted in READY with in_reach=1): left attacker adds HIT_DAMAGE to healthR and pulses hitR; right attacker adds to healthL and pulses hitL.
REQ-021 Health update and hit pulse SHALL be visible on the clock edge that samples the event (one cycle after the keycode change).
REQ-022 Addition SHALL use 9-bit intermediate and saturate at DEATH_LEVEL; health never exceeds DEATH_LEVEL.
REQ-023 Once healthL or healthR >= DEATH_LEVEL, both health values and both FSMs SHALL freeze (no further hits) until fighting=0.
REQ-024 Simultaneous accepted events from both attackers in one cycle SHALL both apply (trade); both may reach DEATH_LEVEL together.
REQ-025 fighting=0 SHALL clear healthL/healthR to 0, force both FSMs to READY, clear counters, hold hit pulses low; press registers keep tracking.
REQ-026 fighting rising while an attack key is already held SHALL NOT generate an event.

Reset
REQ-027 Reset=1 SHALL asynchronously set healthL=healthR=0, hitL=hitR=0, both FSMs READY, counters 0, press registers 0.
REQ-028 Reset asserted mid-cooldown or mid-match SHALL take effect immediately, regardless of clock.

Verification (bench uses COOLDOWN_CYCLES=4)
REQ-029 fighting=1, in_reach=1, keycode2=8'h09 one cycle then 0 -> next edge healthR=16, hitR one cycle, healthL=0.
REQ-030 Hold 8'h09 for 20 cycles, in_reach=1 -> exactly one hit, healthR=16; release, repress after 5 cycles -> healthR=32; repress after 2 cycles -> ignored.
REQ-031 in_reach=0, press 8'h10 -> no damage, no hitL; press again 2 cycles later with in_reach=1 -> ignored (cooldown).
REQ-032 healthR=176, left hit -> 192, right player dead; further presses of either key -> healthL/healthR unchanged; fighting=0 -> both 0.
REQ-033 8'h09 on keycode and 8'h10 on keycode3 same cycle, in_reach=1 -> healthL=16 and healthR=16, hitL and hitR same cycle.
REQ-034 Reset pulsed during cooldown with healthR=48 -> immediate healthR=0, FSM READY; first press after reset release lands.

Source files
------------

// File: rtl/damage_tracker.sv
// Per-player damage accumulator for a two-fighter game.
// Each attack key, on its rising edge, lands one hit and then locks that attacker out for a cooldown period.
module damage_tracker #(
  parameter logic [7:0]  HIT_DAMAGE      = 8'd16,
  parameter logic [7:0]  DEATH_LEVEL     = 8'd192,
  parameter logic [23:0] COOLDOWN_CYCLES = 24'd6_250_000,
  parameter logic [7:0]  ATK_L_KEY       = 8'h09,
  parameter logic [7:0]  ATK_R_KEY       = 8'h10
) (
  input  logic       clk_25MHz,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [7:0] keycode1,
  input  logic [7:0] keycode2,
  input  logic [7:0] keycode3,
  input  logic       fighting,
  input  logic       in_reach,
  output logic [7:0] healthL,
  output logic [7:0] healthR,
  output logic       hitL,
  output logic       hitR
);

  localparam int unsigned CW = 24;
  localparam int unsigned HW = 8;

  typedef enum logic {
    READY    = 1'b0,
    COOLDOWN = 1'b1
  } atk_state_t;

  atk_state_t    state_l, state_l_nxt, state_r, state_r_nxt;
  logic [CW-1:0] cnt_l, cnt_l_nxt, cnt_r, cnt_r_nxt;
  logic [HW-1:0] health_l_nxt, health_r_nxt;
  logic          hit_l_nxt, hit_r_nxt;
  logic          press_l_c, press_r_c, press_l_q, press_r_q;
  logic          event_l_c, event_r_c;
  logic          accept_l_c, accept_r_c;
  logic          dead_c;

  // Saturating add of one hit onto a health value.
  function automatic logic [HW-1:0] sat_add(input logic [HW-1:0] h);
    logic [HW:0] sum;
    sum = {1'b0, h} + {1'b0, HIT_DAMAGE};
    if (sum >= {1'b0, DEATH_LEVEL}) return DEATH_LEVEL;
    return sum[HW-1:0];
  endfunction

  assign press_l_c = (keycode == ATK_L_KEY) || (keycode1 == ATK_L_KEY) ||
                     (keycode2 == ATK_L_KEY) || (keycode3 == ATK_L_KEY);
  assign press_r_c = (keycode == ATK_R_KEY) || (keycode1 == ATK_R_KEY) ||
                     (keycode2 == ATK_R_KEY) || (keycode3 == ATK_R_KEY);
  assign event_l_c = press_l_c && !press_l_q;
  assign event_r_c = press_r_c && !press_r_q;
  assign dead_c    = (healthL >= DEATH_LEVEL) || (healthR >= DEATH_LEVEL);

  // State register; press history keeps tracking even between matches.
  always_ff @(posedge clk_25MHz or posedge Reset) begin
    if (Reset) begin
      state_l   <= READY;
      state_r   <= READY;
      cnt_l     <= '0;
      cnt_r     <= '0;
      healthL   <= '0;
      healthR   <= '0;
      hitL      <= 1'b0;
      hitR      <= 1'b0;
      press_l_q <= 1'b0;
      press_r_q <= 1'b0;
    end else begin
      state_l   <= state_l_nxt;
      state_r   <= state_r_nxt;
      cnt_l     <= cnt_l_nxt;
      cnt_r     <= cnt_r_nxt;
      healthL   <= health_l_nxt;
      healthR   <= health_r_nxt;
      hitL      <= hit_l_nxt;
      hitR      <= hit_r_nxt;
      press_l_q <= press_l_c;
      press_r_q <= press_r_c;
    end
  end

  // Attacker FSMs and damage application; everything holds once a player is dead.
  always_comb begin
    state_l_nxt  = state_l;
    state_r_nxt  = state_r;
    cnt_l_nxt    = cnt_l;
    cnt_r_nxt    = cnt_r;
    health_l_nxt = healthL;
    health_r_nxt = healthR;
    hit_l_nxt    = 1'b0;
    hit_r_nxt    = 1'b0;
    accept_l_c   = 1'b0;
    accept_r_c   = 1'b0;

    if (!fighting) begin
      state_l_nxt  = READY;
      state_r_nxt  = READY;
      cnt_l_nxt    = '0;
      cnt_r_nxt    = '0;
      health_l_nxt = '0;
      health_r_nxt = '0;
    end else if (!dead_c) begin
      case (state_l)
        READY: begin
          if (event_l_c) begin
            accept_l_c  = 1'b1;
            state_l_nxt = COOLDOWN;
            cnt_l_nxt   = COOLDOWN_CYCLES - CW'(1);
          end
        end
        COOLDOWN: begin
          if (cnt_l == '0) state_l_nxt = READY;
          else             cnt_l_nxt   = cnt_l - CW'(1);
        end
      endcase

      case (state_r)
        READY: begin
          if (event_r_c) begin
            accept_r_c  = 1'b1;
            state_r_nxt = COOLDOWN;
            cnt_r_nxt   = COOLDOWN_CYCLES - CW'(1);
          end
        end
        COOLDOWN: begin
          if (cnt_r == '0) state_r_nxt = READY;
          else             cnt_r_nxt   = cnt_r - CW'(1);
        end
      endcase

      // Out-of-reach attacks still consume the cooldown but do no damage.
      if (accept_l_c && in_reach) begin
        health_r_nxt = sat_add(healthR);
        hit_r_nxt    = 1'b1;
      end
      if (accept_r_c && in_reach) begin
        health_l_nxt = sat_add(healthL);
        hit_l_nxt    = 1'b1;
      end
    end
  end

endmodule
